seg_bus_capture: RTL and testbench

- Receiving end of the calculator's multiplexed seven-segment display bus.
- Samples the active-low segment lines and active-low digit anodes, and waits for each digit's drive to settle.
- Decodes each pattern back to a 4-bit hex nibble and assembles all four digits into one 16-bit frame.
- Hands the frame out on a valid/ready interface. Used for display loop-back self-check and for capturing the calculator's result without reading its internal registers.

---
 rtl/seg_pkg.sv | 33 +++
 rtl/seg_bus_capture_if.sv | 32 +++
 rtl/seg_pattern_decode.sv | 41 ++++
 rtl/seg_bus_capture.sv | 218 +++++++++++++++++++++
 tb/tb_seg_bus_capture.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment bus capture block.
//   - SEG_0..SEG_F, SEG_BLANK : active-low font, bit order {g,f,e,d,c,b,a}
//   - N_DIGITS                : number of multiplexed digits on the bus
//   - state_t                 : capture FSM states
package seg_pkg;

  localparam int N_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/seg_bus_capture_if.sv
// Bus bundle between a seven-segment display driver/consumer and the capture
// block.
//   seg_n     : segment lines {g,f,e,d,c,b,a}, 0 = lit
//   an_n      : digit anodes, 0 = selected, bit k = digit k
//   out_value : captured 16-bit frame, digit k in [4k+3:4k]
//   out_blank : per-digit "all segments off" flags
//   out_err   : per-digit "non-font pattern" flags
//   out_valid : frame available
//   out_ready : consumer accepts frame
//   overrun   : one-cycle pulse when a completed frame is dropped
// modport slave  : the capture block
// modport master : the environment (display + frame consumer)
interface seg_bus_capture_if;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic [15:0] out_value;
  logic [3:0]  out_blank;
  logic [3:0]  out_err;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;

  modport slave (
    input  seg_n, an_n, out_ready,
    output out_value, out_blank, out_err, out_valid, overrun
  );

  modport master (
    output seg_n, an_n, out_ready,
    input  out_value, out_blank, out_err, out_valid, overrun
  );
endinterface

// File: rtl/seg_pattern_decode.sv
// Combinational inverse of a hex seven-segment decoder.
//   seg_n  in  7 : active-low pattern {g,f,e,d,c,b,a}
//   nibble out 4 : decoded hex value (0 for blank or unknown patterns)
//   blank  out 1 : pattern is all segments off
//   err    out 1 : pattern is neither a font glyph nor blank
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       err
);

  always_comb begin
    nibble = 4'h0;
    blank  = 1'b0;
    err    = 1'b0;
    case (seg_n)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: blank  = 1'b1;
      default:   err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_bus_capture.sv
// Receiving end of a multiplexed seven-segment display bus. Registers the
// segment and anode lines, waits for each digit's drive to stay identical for
// SETTLE samples, decodes it back to a nibble and assembles four digits into a
// frame handed out on a valid/ready interface.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : seg_bus_capture_if.slave (segment/anode inputs, frame outputs)
// Parameters:
//   SETTLE : identical consecutive samples needed to accept a digit (1..255)
//   CNT_W  : settle counter width, must hold SETTLE
module seg_bus_capture
  import seg_pkg::*;
#(
  parameter int SETTLE = 4,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  seg_bus_capture_if.slave    bus
);

  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);

  // Registered input copies; every decision below uses these.
  logic [6:0] seg_q;
  logic [3:0] an_q;

  // Digit selection decoded from the registered anodes.
  logic       sel_valid;
  logic [1:0] sel_idx;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       lat_sel_q, lat_sel_d;
  logic [6:0]       lat_seg_q, lat_seg_d;
  logic             capture;
  logic             start_new;
  logic             match;
  logic [CNT_W-1:0] cnt_inc;

  logic [N_DIGITS-1:0]   slot_wr;
  logic [N_DIGITS-1:0]   seen_q, seen_d;
  logic [4*N_DIGITS-1:0] slot_val_q, slot_val_d;
  logic [N_DIGITS-1:0]   slot_blank_q, slot_blank_d;
  logic [N_DIGITS-1:0]   slot_err_q, slot_err_d;

  logic [15:0] out_value_q, out_value_d;
  logic [3:0]  out_blank_q, out_blank_d;
  logic [3:0]  out_err_q, out_err_d;
  logic        out_valid_q, out_valid_d;
  logic        overrun_q, overrun_d;

  logic       complete;
  logic       load;
  logic [3:0] dec_nib;
  logic       dec_blank;
  logic       dec_err;

  seg_pattern_decode u_decode (
    .seg_n  (seg_q),
    .nibble (dec_nib),
    .blank  (dec_blank),
    .err    (dec_err)
  );

  // Exactly one anode low selects a digit; anything else means "none".
  always_comb begin
    sel_valid = 1'b1;
    sel_idx   = 2'd0;
    case (an_q)
      4'b1110: sel_idx = 2'd0;
      4'b1101: sel_idx = 2'd1;
      4'b1011: sel_idx = 2'd2;
      4'b0111: sel_idx = 2'd3;
      default: sel_valid = 1'b0;
    endcase
  end

  assign match   = sel_valid && (sel_idx == lat_sel_q) && (seg_q == lat_seg_q);
  assign cnt_inc = cnt_q + CNT_W'(1);

  // Settle FSM. start_new (re)latches the current sample as the first of a
  // new dwell; with SETTLE=1 that first sample is already enough to capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lat_sel_d = lat_sel_q;
    lat_seg_d = lat_seg_q;
    capture   = 1'b0;
    start_new = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_valid) start_new = 1'b1;
      end
      ST_SETTLE: begin
        if (!sel_valid) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (match) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= SETTLE_C) begin
            capture = 1'b1;
            state_d = ST_HOLD;
          end
        end else begin
          start_new = 1'b1;
        end
      end
      ST_HOLD: begin
        // One capture per dwell: stay here until the bus changes.
        if (!sel_valid) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (!match) begin
          start_new = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (start_new) begin
      lat_sel_d = sel_idx;
      lat_seg_d = seg_q;
      cnt_d     = CNT_W'(1);
      if (SETTLE_C <= CNT_W'(1)) begin
        capture = 1'b1;
        state_d = ST_HOLD;
      end else begin
        state_d = ST_SETTLE;
      end
    end
  end

  // Per-slot write strobes and frame assembly.
  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_slot
    assign slot_wr[gi] = capture && (sel_idx == 2'(gi));
  end

  always_comb begin
    slot_val_d   = slot_val_q;
    slot_blank_d = slot_blank_q;
    slot_err_d   = slot_err_q;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (slot_wr[k]) begin
        slot_val_d[4*k +: 4] = dec_nib;
        slot_blank_d[k]      = dec_blank;
        slot_err_d[k]        = dec_err;
      end
    end
  end

  // Completion is seen one cycle after the 4th capture. A capture landing in
  // that same cycle starts the next frame rather than being lost.
  assign complete = &seen_q;
  assign load     = complete && (!out_valid_q || bus.out_ready);

  always_comb begin
    seen_d      = (complete ? '0 : seen_q) | slot_wr;
    out_value_d = out_value_q;
    out_blank_d = out_blank_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    overrun_d   = complete && out_valid_q && !bus.out_ready;
    if (load) begin
      out_value_d = slot_val_q;
      out_blank_d = slot_blank_q;
      out_err_d   = slot_err_q;
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q        <= SEG_BLANK;
      an_q         <= 4'hF;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      lat_sel_q    <= 2'd0;
      lat_seg_q    <= SEG_BLANK;
      seen_q       <= '0;
      slot_val_q   <= '0;
      slot_blank_q <= '0;
      slot_err_q   <= '0;
      out_value_q  <= '0;
      out_blank_q  <= '0;
      out_err_q    <= '0;
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      seg_q        <= bus.seg_n;
      an_q         <= bus.an_n;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lat_sel_q    <= lat_sel_d;
      lat_seg_q    <= lat_seg_d;
      seen_q       <= seen_d;
      slot_val_q   <= slot_val_d;
      slot_blank_q <= slot_blank_d;
      slot_err_q   <= slot_err_d;
      out_value_q  <= out_value_d;
      out_blank_q  <= out_blank_d;
      out_err_q    <= out_err_d;
      out_valid_q  <= out_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.out_value = out_value_q;
  assign bus.out_blank = out_blank_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_seg_bus_capture.sv
module tb_seg_bus_capture;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_bus_capture_if bus_if ();

  seg_bus_capture #(
    .SETTLE (4),
    .CNT_W  (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Segment patterns packed {d3,d2,d1,d0}, 7 bits each.
  typedef struct packed {
    logic [27:0] segs;
    logic        rev;
    logic [15:0] v;
    logic [3:0]  b;
    logic [3:0]  e;
  } vec_t;

  vec_t vecs [5];

  // Transfer monitor: sampled on the falling edge, mid-cycle.
  logic [23:0] xfer_q [$];
  int          ov_cnt = 0;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus_if.out_valid && bus_if.out_ready)
        xfer_q.push_back({bus_if.out_value, bus_if.out_blank, bus_if.out_err});
      if (bus_if.overrun) ov_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  task automatic show(int k, logic [6:0] s, int cyc);
    logic [3:0] a;
    a = 4'b0001 << k;
    bus_if.an_n  = ~a;
    bus_if.seg_n = s;
    repeat (cyc) step();
  endtask

  task automatic idle(int cyc);
    bus_if.an_n  = 4'hF;
    bus_if.seg_n = 7'h7F;
    repeat (cyc) step();
  endtask

  task automatic scan(logic [27:0] segs, logic rev);
    int k;
    for (int i = 0; i < 4; i++) begin
      k = rev ? 3 - i : i;
      show(k, segs[7*k +: 7], 6);
    end
    idle(3);
  endtask

  task automatic expect_frame(string nm, logic [15:0] v, logic [3:0] b, logic [3:0] e);
    logic [23:0] f;
    for (int t = 0; t < 30 && xfer_q.size() == 0; t++) step();
    check({nm, "_count"}, xfer_q.size(), 1);
    if (xfer_q.size() > 0) begin
      f = xfer_q.pop_front();
      check({nm, "_value"}, f[23:8], v);
      check({nm, "_blank"}, f[7:4], b);
      check({nm, "_err"},   f[3:0], e);
    end
    xfer_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{segs: {7'h40, 7'h79, 7'h24, 7'h30}, rev: 1'b0, v: 16'h0123, b: 4'h0, e: 4'h0};
    vecs[1] = '{segs: {7'h0E, 7'h55, 7'h00, 7'h12}, rev: 1'b1, v: 16'hF085, b: 4'h0, e: 4'h4};
    vecs[2] = '{segs: {7'h06, 7'h7F, 7'h21, 7'h7F}, rev: 1'b0, v: 16'hE0D0, b: 4'h5, e: 4'h0};
    vecs[3] = '{segs: {7'h08, 7'h10, 7'h78, 7'h02}, rev: 1'b1, v: 16'hA976, b: 4'h0, e: 4'h0};
    vecs[4] = '{segs: {7'h40, 7'h19, 7'h46, 7'h03}, rev: 1'b0, v: 16'h04CB, b: 4'h0, e: 4'h0};

    rst              = 1'b1;
    bus_if.an_n      = 4'hF;
    bus_if.seg_n     = 7'h7F;
    bus_if.out_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check("rst_valid",   bus_if.out_valid, 0);
    check("rst_value",   bus_if.out_value, 0);
    check("rst_blank",   bus_if.out_blank, 0);
    check("rst_err",     bus_if.out_err, 0);
    check("rst_overrun", bus_if.overrun, 0);
    idle(2);

    // Table-driven full scans with an always-ready consumer.
    for (int i = 0; i < 5; i++) begin
      scan(vecs[i].segs, vecs[i].rev);
      expect_frame($sformatf("vec%0d", i), vecs[i].v, vecs[i].b, vecs[i].e);
    end

    // Short glitch on digit 0 must not be captured; the blank that follows is.
    show(0, 7'h30, 3);
    show(0, 7'h7F, 6);
    show(1, 7'h24, 6);
    show(2, 7'h79, 6);
    show(3, 7'h40, 6);
    idle(3);
    expect_frame("glitch", 16'h0120, 4'h1, 4'h0);

    // Two anodes low: no capture. Digits 1..3 alone must not complete a frame.
    bus_if.an_n  = 4'b1100;
    bus_if.seg_n = 7'h30;
    repeat (10) step();
    show(1, 7'h24, 6);
    show(2, 7'h79, 6);
    show(3, 7'h40, 6);
    idle(3);
    check("multisel_no_frame", xfer_q.size(), 0);
    show(0, 7'h19, 6);
    idle(3);
    expect_frame("multisel", 16'h0124, 4'h0, 4'h0);

    // Back-pressure: first frame held, second completion drops with overrun.
    bus_if.out_ready = 1'b0;
    scan(vecs[0].segs, 1'b0);
    check("bp_valid1", bus_if.out_valid, 1);
    check("bp_value1", bus_if.out_value, 16'h0123);
    begin
      int ov0;
      ov0 = ov_cnt;
      scan(vecs[1].segs, 1'b0);
      check("bp_overrun_pulses", ov_cnt - ov0, 1);
    end
    check("bp_valid2", bus_if.out_valid, 1);
    check("bp_value2", bus_if.out_value, 16'h0123);
    check("bp_err2",   bus_if.out_err, 0);
    bus_if.out_ready = 1'b1;
    step();
    check("bp_valid_drop", bus_if.out_valid, 0);
    expect_frame("bp_xfer", 16'h0123, 4'h0, 4'h0);

    // Reset with a frame pending and two digits already captured.
    bus_if.out_ready = 1'b0;
    scan(vecs[3].segs, 1'b0);
    check("rst2_pre_valid", bus_if.out_valid, 1);
    show(0, 7'h19, 6);
    show(1, 7'h12, 6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_valid",   bus_if.out_valid, 0);
    check("rst2_value",   bus_if.out_value, 0);
    check("rst2_blank",   bus_if.out_blank, 0);
    check("rst2_overrun", bus_if.overrun, 0);
    bus_if.out_ready = 1'b1;
    show(2, 7'h79, 6);
    show(3, 7'h40, 6);
    idle(3);
    check("rst2_no_stale_frame", xfer_q.size(), 0);
    show(0, 7'h30, 6);
    show(1, 7'h24, 6);
    idle(3);
    expect_frame("rst2_frame", 16'h0123, 4'h0, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
